elevator_car_ctrl: RTL and testbench
====================================

# elevator_car_ctrl

Car motion controller that sits directly downstream of the elevator direction FSM. It consumes the 2-bit `direction` command and models the car travelling between floors 0–3 with a fixed per-floor travel time, followed by a timed door-open dwell. It produces the `current_floor` value that the direction FSM consumes, closing the loop, along with status flags for display and door logic.

## Interface
- `TRAVEL_CYCLES`, default 8: clock cycles to travel one floor; legal range 1–256.
- `DOOR_CYCLES`, default 4: clock cycles the door stays open after arrival; legal range 1–256.
- `RESET_FLOOR`, default 2'b00: floor loaded on reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `direction` input 2: movement command. 00 = stay, 01 = up, 10 = down, 11 = treated as stay.
- `current_floor` output 2: registered car position, 0–3.
- `moving` output 1: high while the car is between floors.
- `door_open` output 1: high during the door dwell.
- `arrived` output 1: one-cycle pulse, asserted in the same cycle `current_floor` takes its new value.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. There is one 8-bit `timer`.
- All outputs are registered. On reset: state IDLE, timer 0, `current_floor` = RESET_FLOOR, `moving` = 0, `door_open` = 0, `arrived` = 0.
- **IDLE**
  - `direction` = 01 and floor ≠ 3: go to MOVE_UP, timer ← 0.
  - `direction` = 10 and floor ≠ 0: go to MOVE_DOWN, timer ← 0.
  - Otherwise (stay, 11, up at floor 3, down at floor 0): remain in IDLE with no output change.
- **MOVE_UP / MOVE_DOWN**
  - The timer increments each cycle.
  - On the edge where timer = TRAVEL_CYCLES−1:
    - floor ← floor±1 (no wrap; the IDLE guards make 3→0 and 0→3 impossible);
    - `arrived` ← 1 for one cycle;
    - go to DOOR with timer ← 0.
  - `direction` is ignored while moving. A committed one-floor move always completes; the car never reverses or stops between floors.
- **DOOR**
  - The timer increments each cycle and `direction` is ignored.
  - On the edge where timer = DOOR_CYCLES−1: go to IDLE.
- Output mapping: `moving` = 1 exactly in the MOVE states; `door_open` = 1 exactly in DOOR.
- A `direction` held at 01 from floor 0 walks the car 0→1→2→3, then it parks in IDLE.
- Reset asserted mid-move or mid-dwell aborts immediately: the floor returns to RESET_FLOOR and no `arrived` pulse is generated.

## Timing
- Departure: `direction` is sampled at edge E0 while in IDLE. `moving` = 1 from E0. Nothing is combinational from input to output.
- Arrival: at edge E0+TRAVEL_CYCLES the following all update together: `current_floor`, `arrived` = 1, `moving` = 0, `door_open` = 1.
- Door close: `door_open` falls at edge E0+TRAVEL_CYCLES+DOOR_CYCLES. The earliest next departure edge is one cycle after that.
- Per-floor period with a continuous command: TRAVEL_CYCLES + DOOR_CYCLES + 1 cycles.
- The upstream FSM sees the new `current_floor` one cycle after arrival. Its registered-state latency therefore cannot cause an overshoot, because the command is re-checked only in IDLE.

## Configuration
- `ELEV_DOOR_DWELL_EN` defined: behaviour as above.
- `ELEV_DOOR_DWELL_EN` undefined:
  - the DOOR state is not compiled;
  - arrival goes directly to IDLE;
  - `door_open` is tied to 0 and DOOR_CYCLES is unused;
  - per-floor period is TRAVEL_CYCLES + 1 cycles.

## Test plan
All scenarios use defaults (TRAVEL=8, DOOR=4) with the macro defined unless stated.
- **Reset and idle:** `rst` pulse, then `direction` = 00 for 20 cycles → `current_floor` = 0, `moving` = `door_open` = `arrived` = 0 throughout.
- **Single up move:** `direction` = 01 for one cycle at edge E0, then 00 → `moving` high for edges E0..E0+7; at E0+8 floor = 1 with a one-cycle `arrived`; `door_open` high E0+8..E0+11; back to IDLE at E0+12.
- **Boundaries:** `direction` = 01 held from floor 0 → floors 1, 2, 3 at 13-cycle spacing, then the car stays at 3. `direction` = 10 at floor 0 and 11 at any floor → no movement.
- **Mid-travel reversal:** `direction` switches 01→10 four cycles into a move from floor 1 → car still reaches floor 2, then descends after DOOR.
- **Async reset:** `rst` asserted mid-move from floor 2 (not on a clock edge) → outputs clear immediately, floor = 0, no `arrived` pulse.
- **Macro undefined:** single up move → `door_open` never asserts; second move departs at E0+9.

Source files
------------

// File: rtl/elevator_car_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_car_ctrl
//
// Car motion controller placed directly after the elevator direction FSM.
// It takes the 2-bit direction command, models the car moving one floor at a
// time between floors 0..3 with a fixed travel time, and then holds a timed
// door-open dwell. Its registered current_floor goes back to the direction
// FSM, which closes the control loop.
//
// Optional feature macro: ELEV_DOOR_DWELL_EN
//   defined   : after each arrival the car stays in DOOR for DOOR_CYCLES cycles
//   undefined : DOOR is not built, arrival returns straight to IDLE and
//               door_open is held at 0 (DOOR_CYCLES is then unused)
//
// Parameters
//   TRAVEL_CYCLES : cycles needed to travel one floor (1..256)
//   DOOR_CYCLES   : cycles the door stays open after arrival (1..256)
//   RESET_FLOOR   : floor loaded on reset
//
// Ports
//   clk           : single clock, all state changes on its rising edge
//   rst           : asynchronous, active-high reset
//   direction     : 00 stay, 01 up, 10 down, 11 treated as stay
//   current_floor : registered car position, 0..3
//   moving        : high while the car is between floors
//   door_open     : high during the door dwell
//   arrived       : one-cycle pulse in the same cycle current_floor updates
//
// Every output comes from a flop (or a constant). Nothing is combinational
// from direction to any output.
// -----------------------------------------------------------------------------
module elevator_car_ctrl #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter logic [1:0]  RESET_FLOOR   = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] direction,
  output logic [1:0] current_floor,
  output logic       moving,
  output logic       door_open,
  output logic       arrived
);

  // ---------------------------------------------------------------------------
  // State encoding and constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MOVE_UP   = 2'd1;
  localparam logic [1:0] ST_MOVE_DOWN = 2'd2;
`ifdef ELEV_DOOR_DWELL_EN
  localparam logic [1:0] ST_DOOR      = 2'd3;
`endif

  localparam logic [1:0] DIR_UP       = 2'b01;
  localparam logic [1:0] DIR_DOWN     = 2'b10;

  localparam logic [1:0] TOP_FLOOR    = 2'd3;
  localparam logic [1:0] BOTTOM_FLOOR = 2'd0;

  // The timer counts from 0. The last cycle of a phase is count-1, so a count
  // of 256 still fits in the 8-bit timer as 255.
  localparam logic [7:0] TRAVEL_LAST  = 8'(TRAVEL_CYCLES - 1);
`ifdef ELEV_DOOR_DWELL_EN
  localparam logic [7:0] DOOR_LAST    = 8'(DOOR_CYCLES - 1);
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [1:0] state_q,     state_d;
  logic [7:0] timer_q,     timer_d;
  logic [1:0] floor_q,     floor_d;
  logic       moving_q,    moving_d;
  logic       arrived_q,   arrived_d;
`ifdef ELEV_DOOR_DWELL_EN
  logic       door_open_q, door_open_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case. A path that
    // skipped an assignment would otherwise infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    floor_d   = floor_q;
    arrived_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A request to move past the top or bottom floor is ignored, so the
        // floor arithmetic below never has to wrap.
        if (direction == DIR_UP && floor_q != TOP_FLOOR) begin
          state_d = ST_MOVE_UP;
          timer_d = 8'd0;
        end else if (direction == DIR_DOWN && floor_q != BOTTOM_FLOOR) begin
          state_d = ST_MOVE_DOWN;
          timer_d = 8'd0;
        end
      end

      ST_MOVE_UP, ST_MOVE_DOWN: begin
        // direction is not looked at here. Once a one-floor move starts it
        // always finishes, so a command change cannot stop or reverse the car
        // between floors.
        if (timer_q == TRAVEL_LAST) begin
          floor_d   = (state_q == ST_MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
          arrived_d = 1'b1;
          timer_d   = 8'd0;
`ifdef ELEV_DOOR_DWELL_EN
          state_d   = ST_DOOR;
`else
          state_d   = ST_IDLE;
`endif
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

`ifdef ELEV_DOOR_DWELL_EN
      ST_DOOR: begin
        // The upstream FSM sees the new floor one cycle after arrival. It
        // cannot overshoot because its command is only sampled again in IDLE.
        if (timer_q == DOOR_LAST) begin
          state_d = ST_IDLE;
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        timer_d = 8'd0;
      end
    endcase

    // The status flags are decoded from the next state and then registered.
    // This way they change on the same edge as the state they describe.
    moving_d = (state_d == ST_MOVE_UP) || (state_d == ST_MOVE_DOWN);
`ifdef ELEV_DOOR_DWELL_EN
    door_open_d = (state_d == ST_DOOR);
`endif
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= 8'd0;
      floor_q   <= RESET_FLOOR;
      moving_q  <= 1'b0;
      arrived_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments ensure every flop samples values from
      // before the edge, whatever order the statements are written in.
      state_q   <= state_d;
      timer_q   <= timer_d;
      floor_q   <= floor_d;
      moving_q  <= moving_d;
      arrived_q <= arrived_d;
    end
  end

`ifdef ELEV_DOOR_DWELL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      door_open_q <= 1'b0;
    end else begin
      door_open_q <= door_open_d;
    end
  end

  assign door_open = door_open_q;
`else
  // No dwell phase is built, so the door flag is a constant and the door
  // timing parameter has nothing to drive.
  assign door_open = 1'b0;

  logic [7:0] door_cfg_unused;
  assign door_cfg_unused = 8'(DOOR_CYCLES);
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign current_floor = floor_q;
  assign moving        = moving_q;
  assign arrived       = arrived_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_car_ctrl
//
// Directed testbench for elevator_car_ctrl with TRAVEL_CYCLES=8 and
// DOOR_CYCLES=4. The expected values are derived from the edge timing of the
// car. They follow whichever ELEV_DOOR_DWELL_EN setting the bench is compiled
// with: without the dwell the door phase takes zero cycles and door_open
// stays low.
//
// Inputs are driven 1 ns after a rising edge, and outputs are sampled at that
// same point. The edge that samples a command is called E0, and t is the
// number of edges after E0.
// -----------------------------------------------------------------------------
module tb_elevator_car_ctrl;

  localparam int TRAVEL = 8;
  localparam int DOOR   = 4;
`ifdef ELEV_DOOR_DWELL_EN
  localparam bit DWELL  = 1'b1;
`else
  localparam bit DWELL  = 1'b0;
`endif
  // Length of the dwell phase in this build, and the period between floors
  // when the command is held.
  localparam int DOORC  = DWELL ? DOOR : 0;
  localparam int PERIOD = TRAVEL + DOORC + 1;

  localparam logic [1:0] STAY = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;
  localparam logic [1:0] BOTH = 2'b11;

  logic       clk;
  logic       rst;
  logic [1:0] direction;
  logic [1:0] current_floor;
  logic       moving;
  logic       door_open;
  logic       arrived;

  // Observed output vector: {floor[1:0], moving, door_open, arrived}
  logic [4:0] obs;
  assign obs = {current_floor, moving, door_open, arrived};

  int n_checks = 0;
  int n_fail   = 0;

  elevator_car_ctrl #(
    .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES  (DOOR),
    .RESET_FLOOR  (2'b00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .direction    (direction),
    .current_floor(current_floor),
    .moving       (moving),
    .door_open    (door_open),
    .arrived      (arrived)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs t edges after a one-floor move departs from f_from
  function automatic logic [4:0] move_exp(input int t, input logic [1:0] f_from,
                                          input logic [1:0] f_to);
    if (t < TRAVEL)             return {f_from, 1'b1, 1'b0, 1'b0};
    else if (t == TRAVEL)       return {f_to, 1'b0, DWELL, 1'b1};
    else if (t < TRAVEL + DOORC) return {f_to, 1'b0, 1'b1, 1'b0};
    else                        return {f_to, 1'b0, 1'b0, 1'b0};
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [4:0] exp;
    rst = 1'b1;
    direction = STAY;
    #3;
    exp = 5'b00_0_0_0;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs, exp);
    end
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_idle t=%0d: got %b expected %b", t, obs, exp);
      end
    end
  endtask

  // Down at floor 0 and the code 11 must not move the car
  task automatic test_blocked();
    logic [4:0] exp;
    exp = 5'b00_0_0_0;
    for (int t = 0; t < 8; t++) begin
      direction = (t < 4) ? DOWN : BOTH;
      tick();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL blocked_floor0 t=%0d: got %b expected %b", t, obs, exp);
      end
    end
    direction = STAY;
  endtask

  // One-cycle up request from floor 0
  task automatic test_single_up();
    logic [4:0] exp;
    direction = UP;
    for (int t = 0; t <= TRAVEL + DOORC + 1; t++) begin
      tick();
      direction = STAY;
      exp = move_exp(t, 2'd0, 2'd1);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL single_up t=%0d: got %b expected %b", t, obs, exp);
      end
    end
  endtask

  // Command changes from up to down four cycles into a move from floor 1.
  // The up move still completes, and the car descends after the door phase.
  task automatic test_reversal();
    logic [4:0] exp;
    direction = UP;
    for (int t = 0; t <= TRAVEL + DOORC; t++) begin
      tick();
      if (t == 3) direction = DOWN;
      exp = move_exp(t, 2'd1, 2'd2);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reversal_up t=%0d: got %b expected %b", t, obs, exp);
      end
    end
    for (int t = 0; t <= TRAVEL + DOORC; t++) begin
      tick();
      direction = STAY;
      exp = move_exp(t, 2'd2, 2'd1);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reversal_down t=%0d: got %b expected %b", t, obs, exp);
      end
    end
  endtask

  // Up held from floor 0: the car walks 0->1->2->3 and then parks at 3.
  // The arrivals come PERIOD cycles apart, which also checks the spacing of
  // back-to-back departures.
  task automatic test_walk_up();
    logic [4:0] exp;
    int s;
    int r;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp = 5'b00_0_0_0;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL walk_reset: got %b expected %b", obs, exp);
    end
    direction = UP;
    for (int t = 0; t < 3 * PERIOD + 6; t++) begin
      tick();
      s = t / PERIOD;
      r = t % PERIOD;
      if (s < 3) begin
        exp[4:3] = 2'(s + ((r >= TRAVEL) ? 1 : 0));
        exp[2]   = (r < TRAVEL);
        exp[1]   = DWELL && (r >= TRAVEL) && (r < TRAVEL + DOORC);
        exp[0]   = (r == TRAVEL);
      end else begin
        exp = 5'b11_0_0_0;
      end
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL walk_up t=%0d: got %b expected %b", t, obs, exp);
      end
    end
    // The code 11 at the top floor is also a stay
    direction = BOTH;
    exp = 5'b11_0_0_0;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL top_code11 t=%0d: got %b expected %b", t, obs, exp);
      end
    end
    direction = STAY;
  endtask

  // Reset asserted between clock edges while the car is moving down from
  // floor 2. The outputs must clear at once, and no arrived pulse may follow.
  task automatic test_async_reset();
    logic [4:0] exp;
    direction = DOWN;
    for (int t = 0; t < PERIOD + 3; t++) begin
      tick();
      if (t < PERIOD) exp = move_exp(t, 2'd3, 2'd2);
      else            exp = 5'b10_1_0_0;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL pre_reset_move t=%0d: got %b expected %b", t, obs, exp);
      end
    end
    #3;
    rst = 1'b1;
    #1;
    exp = 5'b00_0_0_0;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b expected %b", obs, exp);
    end
    direction = STAY;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_held t=%0d: got %b expected %b", t, obs, exp);
      end
    end
    #2;
    rst = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL post_reset t=%0d: got %b expected %b", t, obs, exp);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    direction = STAY;
    test_reset();
    test_blocked();
    test_single_up();
    test_reversal();
    test_walk_up();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
